// File: rtl/ps_buffer_arbiter_pkg.sv
// Shared types and helpers for the PS shared-memory (BRAM) buffer arbiter.
//   t_buf_req   : one registered memory-side request (byte enables, byte address, write data)
//   t_arb_state : arbiter FSM states (free round-robin vs. locked burst owner)
//   next_index  : modulo increment used for round-robin pointer and scan order
package ps_buffer_arbiter_pkg;

    localparam int unsigned BUF_WORD_BYTES = 4;
    localparam int unsigned BUF_DATA_W     = 8 * BUF_WORD_BYTES;
    localparam int unsigned BUF_ADDR_W     = 32;
    localparam int unsigned BUF_BYTE_OFS_W = $clog2(BUF_WORD_BYTES);

    typedef struct packed {
        logic [BUF_WORD_BYTES-1:0] we;
        logic [BUF_ADDR_W-1:0]     addr;
        logic [BUF_DATA_W-1:0]     wdata;
    } t_buf_req;

    typedef enum logic [0:0] {
        StIdle,
        StOwned
    } t_arb_state;

    // (idx + 1) mod n, without a divider
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ps_buffer_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: grants the first requesting index at or after ptr_i,
// wrapping modulo N_REQ.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   gnt_o   : one-hot grant (zero when nothing requests)
//   idx_o   : binary index of the granted requester
//   valid_o : some requester was picked
module ps_buffer_arbiter_rr_priority_picker
    import ps_buffer_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned scan_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        scan_idx = 32'(ptr_i);
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!valid_o && req_i[scan_idx]) begin
                gnt_o[scan_idx] = 1'b1;
                idx_o           = PTR_W'(scan_idx);
                valid_o         = 1'b1;
            end
            scan_idx = next_index(scan_idx, N_REQ);
        end
    end

endmodule

// File: rtl/ps_buffer_arbiter.sv
// Shares the single 32-bit PS BRAM port between N_REQ requesters in the 40 MHz domain.
// Round-robin arbitration with optional locked bursts, registered memory-side outputs and
// a tagged read pipeline that returns read data to the originating requester.
//   clk, reset_n        : buffer clock, asynchronous active-low reset
//   req_i / lock_i      : per-requester transfer request / keep-grant (burst) request
//   we_i/addr_i/wdata_i : per-requester byte enables (0 = read), word address, write data
//   gnt_o               : one-hot combinational grant; req_i & gnt_o = transfer accepted
//   rvalid_o / rdata_o  : per-requester read-valid strobe and shared read data bus
//   mem_*               : registered BRAM port (enable, byte we, byte address, din, dout)
//   busy_o              : burst owner held, memory access issued or read in flight
module ps_buffer_arbiter
    import ps_buffer_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [N_REQ-1:0]                      req_i,
    input  logic [N_REQ-1:0]                      lock_i,
    input  logic [N_REQ-1:0][BUF_WORD_BYTES-1:0]  we_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]          addr_i,
    input  logic [N_REQ-1:0][BUF_DATA_W-1:0]      wdata_i,
    output logic [N_REQ-1:0]                      gnt_o,
    output logic [N_REQ-1:0]                      rvalid_o,
    output logic [BUF_DATA_W-1:0]                 rdata_o,
    output logic                                  mem_en_o,
    output logic [BUF_WORD_BYTES-1:0]             mem_we_o,
    output logic [BUF_ADDR_W-1:0]                 mem_addr_o,
    output logic [BUF_DATA_W-1:0]                 mem_din_o,
    input  logic [BUF_DATA_W-1:0]                 mem_dout_i,
    output logic                                  busy_o
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    t_arb_state       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;

    logic             xfer;
    logic [PTR_W-1:0] xfer_idx;
    t_buf_req         sel_req;

    t_buf_req         mem_q;
    logic             mem_en_q;

    // Slot 0 lines up with the registered mem_en_o; slot RD_LATENCY with valid BRAM data.
    logic [RD_LATENCY:0]            rd_vld_q;
    logic [RD_LATENCY:0][PTR_W-1:0] rd_tag_q;

    ps_buffer_arbiter_rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    // ---------------------------------------------------------------------------------
    // Arbitration FSM
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_o   = '0;

        unique case (state_q)
            StIdle: begin
                gnt_o = pick_gnt;
                if (pick_vld) begin
                    if (lock_i[pick_idx]) begin
                        state_d = StOwned;
                        owner_d = pick_idx;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        ptr_d = PTR_W'(next_index(32'(pick_idx), N_REQ));
                    end
                end
            end

            StOwned: begin
                // Leaving the burst always costs one cycle with no grant, so the
                // other requesters see the pointer move before competing again.
                if (cnt_q >= MAX_CNT || !req_i[owner_q]) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    ptr_d   = PTR_W'(next_index(32'(owner_q), N_REQ));
                end else begin
                    gnt_o[owner_q] = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                    // Unlocked transfer ends the burst: saturate so the next cycle exits.
                    if (!lock_i[owner_q]) begin
                        cnt_d = MAX_CNT;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Transfer selection and registered memory port
    // ---------------------------------------------------------------------------------
    // gnt_o is only set for a requesting index, so any grant bit is an accepted transfer.
    assign xfer     = |(req_i & gnt_o);
    assign xfer_idx = (state_q == StOwned) ? owner_q : pick_idx;

    always_comb begin
        sel_req       = '0;
        sel_req.we    = we_i[xfer_idx];
        sel_req.addr  = BUF_ADDR_W'({addr_i[xfer_idx], {BUF_BYTE_OFS_W{1'b0}}});
        sel_req.wdata = wdata_i[xfer_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q <= 1'b0;
            mem_q    <= '0;
        end else begin
            mem_en_q <= xfer;
            mem_q    <= xfer ? sel_req : '0;
        end
    end

    assign mem_en_o   = mem_en_q;
    assign mem_we_o   = mem_q.we;
    assign mem_addr_o = mem_q.addr;
    assign mem_din_o  = mem_q.wdata;

    // ---------------------------------------------------------------------------------
    // Tagged read-return pipeline
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= '0;
            rd_tag_q <= '0;
        end else begin
            rd_vld_q[0] <= xfer && (sel_req.we == '0);
            rd_tag_q[0] <= xfer_idx;
            for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_tag_q[k] <= rd_tag_q[k-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rvalid_o[i] = rd_vld_q[RD_LATENCY] && (rd_tag_q[RD_LATENCY] == PTR_W'(i));
        end
    end

    // Gated so the shared bus stays quiet between returns and during reset.
    assign rdata_o = rd_vld_q[RD_LATENCY] ? mem_dout_i : '0;

    assign busy_o = (state_q == StOwned) | mem_en_q | (|rd_vld_q);

endmodule

// File: tb/tb_ps_buffer_arbiter.sv
module tb_ps_buffer_arbiter;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [2:0][3:0]   we;
    logic [2:0][11:0]  addr;
    logic [2:0][31:0]  wdata;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [31:0]       rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       bram_dout = 32'h0;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps_buffer_arbiter #(
        .N_REQ      (3),
        .ADDR_W     (12),
        .RD_LATENCY (1),
        .MAX_BURST  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req),
        .lock_i     (lock),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_dout_i (bram_dout),
        .busy_o     (busy)
    );

    // BRAM model, 1-cycle read latency; word a preloaded with 32'hA500_0000 | a.
    logic [31:0] bram [0:4095];
    logic        bram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!bram_loaded) begin
            for (int a = 0; a < 4096; a++) bram[a] <= 32'hA500_0000 | 32'(a);
            bram_loaded <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr[13:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end
            if (mem_we == 4'h0) bram_dout <= bram[mem_addr[13:2]];
        end
    end

    typedef struct {
        logic [2:0]  req;
        logic [11:0] we;
        logic [35:0] addr;
        logic [95:0] wdata;
        logic [2:0]  gnt;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_din;
        logic [2:0]  rvalid;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] r, logic [11:0] w, logic [35:0] a, logic [95:0] d,
                                logic [2:0] g, logic en, logic [3:0] mw, logic [31:0] ma,
                                logic [31:0] md, logic [2:0] rv, logic [31:0] rd, logic bz);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.wdata = d;
        v.gnt = g; v.mem_en = en; v.mem_we = mw; v.mem_addr = ma; v.mem_din = md;
        v.rvalid = rv; v.rdata = rd; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [11:0] w,
                         input logic [35:0] a, input logic [95:0] d);
        @(negedge clk);
        req = r; lock = l; we = w; addr = a; wdata = d;
        #2;
    endtask

    localparam logic [35:0] A_RR  = {12'h003, 12'h002, 12'h001};
    localparam logic [35:0] A_W0  = {12'h000, 12'h000, 12'h005};
    localparam logic [35:0] A_R2  = {12'h005, 12'h000, 12'h000};
    localparam logic [35:0] A_P1  = {12'h000, 12'h006, 12'h000};
    localparam logic [95:0] D_W0  = {32'h0, 32'h0, 32'hDEADBEEF};
    localparam logic [95:0] D_P1  = {32'h0, 32'h11223344, 32'h0};

    initial begin
        reset_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        // req  we  addr  wdata | gnt en mwe maddr mdin rvalid rdata busy
        // single read from 0 at word 0x010
        vecs.push_back(mk(3'b001, 12'h0, 36'h010, 96'h0, 3'b001, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 1, 4'h0, 32'h40, 32'h0, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, 32'hA5000010, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        // contention, pointer now at 1: order 1,2,0,1
        vecs.push_back(mk(3'b111, 12'h0, A_RR, 96'h0, 3'b010, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        vecs.push_back(mk(3'b111, 12'h0, A_RR, 96'h0, 3'b100, 1, 4'h0, 32'h8, 32'h0, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b111, 12'h0, A_RR, 96'h0, 3'b001, 1, 4'h0, 32'hC, 32'h0, 3'b010, 32'hA5000002, 1));
        vecs.push_back(mk(3'b111, 12'h0, A_RR, 96'h0, 3'b010, 1, 4'h0, 32'h4, 32'h0, 3'b100, 32'hA5000003, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 1, 4'h0, 32'h8, 32'h0, 3'b001, 32'hA5000001, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b010, 32'hA5000002, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        // write DEADBEEF from 0 to word 5, read back from 2
        vecs.push_back(mk(3'b001, 12'h00F, A_W0, D_W0, 3'b001, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        vecs.push_back(mk(3'b100, 12'h0, A_R2, 96'h0, 3'b100, 1, 4'hF, 32'h14, 32'hDEADBEEF, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 1, 4'h0, 32'h14, 32'h0, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b100, 32'hDEADBEEF, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        // partial write (we=0011) from 1 to word 6, then read back from 1
        vecs.push_back(mk(3'b010, 12'h030, A_P1, D_P1, 3'b010, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));
        vecs.push_back(mk(3'b010, 12'h0, A_P1, 96'h0, 3'b010, 1, 4'h3, 32'h18, 32'h11223344, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 1, 4'h0, 32'h18, 32'h0, 3'b000, 32'h0, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b010, 32'hA5003344, 1));
        vecs.push_back(mk(3'b000, 12'h0, 36'h0, 96'h0, 3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0, 0));

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset mem_en", 32'(mem_en), 32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, 3'b000, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vecs[i].mem_en));
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].mem_en) begin
                chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mem_we));
                chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].mem_addr);
            end
            if (vecs[i].mem_we != 4'h0) chk($sformatf("row%0d mem_din", i), mem_din, vecs[i].mem_din);
            if (vecs[i].rvalid != 3'b000) chk($sformatf("row%0d rdata", i), rdata, vecs[i].rdata);
        end

        // locked burst by 1 (pointer at 2), 0 and 2 also requesting: 16 grants, gap, then 2
        drive(3'b010, 3'b010, 12'hFFF, 36'h0, 96'h0);
        chk("burst first gnt", 32'(gnt), 32'h2);
        for (int k = 1; k < 16; k++) begin
            drive(3'b111, 3'b010, 12'hFFF, 36'h0, 96'h0);
            chk($sformatf("burst%0d gnt", k), 32'(gnt), 32'h2);
            chk($sformatf("burst%0d mem_en", k), 32'(mem_en), 32'h1);
        end
        drive(3'b111, 3'b010, 12'hFFF, 36'h0, 96'h0);
        chk("burst gap gnt", 32'(gnt), 32'h0);
        chk("burst gap mem_en", 32'(mem_en), 32'h1);
        chk("burst gap busy", 32'(busy), 32'h1);
        drive(3'b111, 3'b010, 12'hFFF, 36'h0, 96'h0);
        chk("burst after gnt", 32'(gnt), 32'h4);
        chk("burst after mem_en", 32'(mem_en), 32'h0);
        drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("burst tail mem_en", 32'(mem_en), 32'h1);
        drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("burst idle busy", 32'(busy), 32'h0);

        // requester 1 drops its request while 0 owns a locked burst
        drive(3'b001, 3'b001, 12'hFFF, 36'h0, 96'h0);
        chk("drop d0 gnt", 32'(gnt), 32'h1);
        drive(3'b011, 3'b001, 12'hFFF, 36'h0, 96'h0);
        chk("drop d1 gnt", 32'(gnt), 32'h1);
        drive(3'b001, 3'b001, 12'hFFF, 36'h0, 96'h0);
        chk("drop d2 gnt", 32'(gnt), 32'h1);
        drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("drop d3 gnt", 32'(gnt), 32'h0);
        chk("drop d3 busy", 32'(busy), 32'h1);
        drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("drop d4 busy", 32'(busy), 32'h0);
        chk("drop d4 mem_en", 32'(mem_en), 32'h0);

        // reset one cycle after a read transfer (pointer ends at 2 before reset)
        drive(3'b010, 3'b000, 12'h0, {12'h0, 12'h007, 12'h0}, 96'h0);
        chk("rst read gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        reset_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        #2;
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_din", mem_din, 32'h0);
        chk("rst rvalid", 32'(rvalid), 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("rst release rvalid", 32'(rvalid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
            chk($sformatf("rst drain%0d rvalid", k), 32'(rvalid), 32'h0);
        end
        drive(3'b111, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("rst first gnt", 32'(gnt), 32'h1);
        drive(3'b000, 3'b000, 12'h0, 36'h0, 96'h0);
        chk("rst first mem_en", 32'(mem_en), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
